// File: rtl/pintor_cuadro.sv
// pintor_cuadro: paints a LADO x LADO square of one colour into a framebuffer
// write port (ready/valid), or erases the last painted square with colour 0.
// Optional feature macro: PINTOR_CLIP_EN -- when defined, pixels that fall
// outside H_RES x V_RES are skipped (one idle cycle each) instead of written.
module pintor_cuadro #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int LADO  = 4,
  parameter int AW    = 15,
  parameter int CW    = 3
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iPintar,
  input  logic          iResetPintar,
  input  logic [7:0]    iPosX,
  input  logic [6:0]    iPosY,
  input  logic [CW-1:0] iColor,
  output logic [AW-1:0] oWrAddr,
  output logic [CW-1:0] oWrData,
  output logic          oWrEn,
  input  logic          iWrReady,
  output logic          oListo,
  output logic          oOcupado
);

  // Side counters cover LADO up to 16, i.e. offsets 0..15.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(LADO - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [7:0]       pos_x_q, pos_x_d;
  logic [6:0]       pos_y_q, pos_y_d;
  logic [CW-1:0]    color_q, color_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [CW-1:0]    wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             listo_q, listo_d;
  logic             ocupado_q, ocupado_d;

  logic             advance_s;
  logic             last_s;
  logic             present_s;
  logic [7:0]       pix_bx_s;
  logic [6:0]       pix_by_s;
  logic [CNT_W-1:0] pix_dx_s, pix_dy_s;
  logic [CW-1:0]    pix_data_s;

  // Linear framebuffer address of pixel (bx+dx, by+dy), full precision then truncated.
  function automatic logic [AW-1:0] pix_addr(input logic [7:0] bx, input logic [6:0] by,
                                             input logic [CNT_W-1:0] dx, input logic [CNT_W-1:0] dy);
    logic [31:0] x, y, a;
    x = 32'(bx) + 32'(dx);
    y = 32'(by) + 32'(dy);
    a = y * 32'(H_RES) + x;
    return a[AW-1:0];
  endfunction

`ifdef PINTOR_CLIP_EN
  // True when pixel (bx+dx, by+dy) lies inside the visible frame.
  function automatic logic pix_in_range(input logic [7:0] bx, input logic [6:0] by,
                                        input logic [CNT_W-1:0] dx, input logic [CNT_W-1:0] dy);
    logic [31:0] x, y;
    x = 32'(bx) + 32'(dx);
    y = 32'(by) + 32'(dy);
    return (x < 32'(H_RES)) && (y < 32'(V_RES));
  endfunction
`endif

  // A presented pixel leaves when accepted; a skipped pixel (oWrEn low) leaves after one cycle.
  assign advance_s = wr_en_q ? iWrReady : 1'b1;
  assign last_s    = (dx_q == LAST_OFS) && (dy_q == LAST_OFS);

  // State register.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; erase has priority over paint, busy states ignore commands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iResetPintar) begin
          state_d = ST_CLEAR;
        end else if (iPintar) begin
          state_d = ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (advance_s && last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_CLEAR: begin
        if (advance_s && last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: latch command, step the scan, build the next write.
  always_comb begin
    dx_d       = dx_q;
    dy_d       = dy_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    color_d    = color_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = wr_en_q;
    present_s  = 1'b0;
    pix_bx_s   = pos_x_q;
    pix_by_s   = pos_y_q;
    pix_dx_s   = '0;
    pix_dy_s   = '0;
    pix_data_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (iResetPintar) begin
          dx_d       = '0;
          dy_d       = '0;
          present_s  = 1'b1;
          pix_data_s = '0;
        end else if (iPintar) begin
          pos_x_d    = iPosX;
          pos_y_d    = iPosY;
          color_d    = iColor;
          dx_d       = '0;
          dy_d       = '0;
          present_s  = 1'b1;
          pix_bx_s   = iPosX;
          pix_by_s   = iPosY;
          pix_data_s = iColor;
        end else begin
          wr_en_d = 1'b0;
        end
      end
      ST_DRAW, ST_CLEAR: begin
        if (advance_s) begin
          if (last_s) begin
            dx_d      = '0;
            dy_d      = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
          end else begin
            if (dx_q == LAST_OFS) begin
              dx_d = '0;
              dy_d = dy_q + 4'd1;
            end else begin
              dx_d = dx_q + 4'd1;
              dy_d = dy_q;
            end
            present_s  = 1'b1;
            pix_dx_s   = dx_d;
            pix_dy_s   = dy_d;
            pix_data_s = (state_q == ST_DRAW) ? color_q : {CW{1'b0}};
          end
        end else begin
          wr_en_d = wr_en_q;
        end
      end
      ST_DONE: begin
        wr_en_d = 1'b0;
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase

    if (present_s) begin
      wr_addr_d = pix_addr(pix_bx_s, pix_by_s, pix_dx_s, pix_dy_s);
      wr_data_d = pix_data_s;
`ifdef PINTOR_CLIP_EN
      wr_en_d   = pix_in_range(pix_bx_s, pix_by_s, pix_dx_s, pix_dy_s);
`else
      wr_en_d   = 1'b1;
`endif
    end else begin
      wr_addr_d = wr_addr_d;
    end
  end

  // Status flags follow the state the machine is entering.
  assign listo_d   = (state_d == ST_DONE);
  assign ocupado_d = (state_d != ST_IDLE);

  // Datapath and output registers.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      dx_q      <= '0;
      dy_q      <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      color_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      color_q   <= color_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign oWrAddr  = wr_addr_q;
  assign oWrData  = wr_data_q;
  assign oWrEn    = wr_en_q;
  assign oListo   = listo_q;
  assign oOcupado = ocupado_q;

endmodule

// File: tb/tb_pintor_cuadro.sv
// Directed bench for pintor_cuadro: paint, stall, clip, erase, ignored command, async reset.
module tb_pintor_cuadro;
  localparam int AW = 15;
  localparam int CW = 3;

  logic          iClk = 1'b0;
  logic          iReset;
  logic          iPintar;
  logic          iResetPintar;
  logic [7:0]    iPosX;
  logic [6:0]    iPosY;
  logic [CW-1:0] iColor;
  logic [AW-1:0] oWrAddr;
  logic [CW-1:0] oWrData;
  logic          oWrEn;
  logic          iWrReady;
  logic          oListo;
  logic          oOcupado;

  pintor_cuadro #(.H_RES(160), .V_RES(120), .LADO(4), .AW(AW), .CW(CW)) dut (
    .iClk(iClk), .iReset(iReset), .iPintar(iPintar), .iResetPintar(iResetPintar),
    .iPosX(iPosX), .iPosY(iPosY), .iColor(iColor),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrEn(oWrEn), .iWrReady(iWrReady),
    .oListo(oListo), .oOcupado(oOcupado)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa [0:31];
  logic [CW-1:0] wd [0:31];
  logic [AW-1:0] cyc_addr [0:40];
  logic          cyc_en   [0:40];
  int n_wr, listo_cnt, listo_cyc, busy_last;

  task automatic chk_eq(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Number of the 16 logged writes that differ from the expected row-major square.
  function automatic int sq_errs(input int bx, input int by, input int dat);
    int e;
    logic [AW-1:0] ea;
    e = 0;
    for (int k = 0; k < 16; k++) begin
      ea = AW'((by + k / 4) * 160 + bx + k % 4);
      if (k >= n_wr) e++;
      else if (wa[k] !== ea || wd[k] !== CW'(dat)) e++;
    end
    return e;
  endfunction

  // Pulse a command at cycle 0, then observe 30 cycles; iWrReady low in [slo,shi];
  // a stray iPintar with a different position is pulsed at cycle rep (0 = none).
  task automatic run_cmd(input logic pin, input logic era, input logic [7:0] x, input logic [6:0] y,
                         input logic [CW-1:0] col, input int slo, input int shi, input int rep);
    n_wr = 0; listo_cnt = 0; listo_cyc = 0; busy_last = 0;
    iPintar = pin; iResetPintar = era; iPosX = x; iPosY = y; iColor = col; iWrReady = 1'b1;
    @(posedge iClk); #1;
    iPintar = 1'b0; iResetPintar = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      iWrReady = !(c >= slo && c <= shi);
      if (c == rep) begin
        iPintar = 1'b1; iPosX = 8'd99; iPosY = 7'd50; iColor = 3'd2;
      end else begin
        iPintar = 1'b0;
      end
      cyc_addr[c] = oWrAddr;
      cyc_en[c]   = oWrEn;
      if (oOcupado) busy_last = c;
      if (oListo) begin
        listo_cnt++;
        listo_cyc = c;
      end
      if (oWrEn && iWrReady && n_wr < 32) begin
        wa[n_wr] = oWrAddr;
        wd[n_wr] = oWrData;
        n_wr++;
      end
      @(posedge iClk); #1;
    end
    iPintar = 1'b0;
  endtask

  initial begin
    iReset = 1'b0; iPintar = 1'b0; iResetPintar = 1'b0;
    iPosX = 8'd0; iPosY = 7'd0; iColor = 3'd0; iWrReady = 1'b1;
    n_wr = 0; listo_cnt = 0; listo_cyc = 0; busy_last = 0;
    repeat (3) @(posedge iClk);
    #1;
    chk_eq("rst_wren", oWrEn, 0);
    chk_eq("rst_listo", oListo, 0);
    chk_eq("rst_busy", oOcupado, 0);
    chk_eq("rst_addr", oWrAddr, 0);
    iReset = 1'b1;
    @(posedge iClk); #1;

    // Plain paint at (10,20), colour 5.
    run_cmd(1'b1, 1'b0, 8'd10, 7'd20, 3'd5, 0, 0, 0);
    chk_eq("draw_nwr", n_wr, 16);
    chk_eq("draw_first", wa[0], 3210);
    chk_eq("draw_last", wa[15], 3693);
    chk_eq("draw_square", sq_errs(10, 20, 5), 0);
    chk_eq("draw_listo_cnt", listo_cnt, 1);
    chk_eq("draw_listo_cyc", listo_cyc, 17);
    chk_eq("draw_busy_last", busy_last, 17);

    // Same paint with iWrReady low in cycles 3..5.
    run_cmd(1'b1, 1'b0, 8'd10, 7'd20, 3'd5, 3, 5, 0);
    chk_eq("stall_addr_c3", cyc_addr[3], 3212);
    chk_eq("stall_addr_c5", cyc_addr[5], 3212);
    chk_eq("stall_en_c4", cyc_en[4], 1);
    chk_eq("stall_en_c5", cyc_en[5], 1);
    chk_eq("stall_nwr", n_wr, 16);
    chk_eq("stall_square", sq_errs(10, 20, 5), 0);
    chk_eq("stall_listo_cyc", listo_cyc, 20);
    chk_eq("stall_busy_last", busy_last, 20);

    // Square straddling the right edge at (158,0).
    run_cmd(1'b1, 1'b0, 8'd158, 7'd0, 3'd3, 0, 0, 0);
`ifdef PINTOR_CLIP_EN
    chk_eq("clip_nwr", n_wr, 8);
    chk_eq("clip_last", wa[7], 639);
`else
    chk_eq("clip_nwr", n_wr, 16);
    chk_eq("clip_last", wa[15], 641);
`endif
    chk_eq("clip_listo_cyc", listo_cyc, 17);
    chk_eq("clip_listo_cnt", listo_cnt, 1);

    // Paint (10,20), then erase and paint together: erase wins, stored position used.
    run_cmd(1'b1, 1'b0, 8'd10, 7'd20, 3'd5, 0, 0, 0);
    run_cmd(1'b1, 1'b1, 8'd50, 7'd50, 3'd6, 0, 0, 0);
    chk_eq("clr_nwr", n_wr, 16);
    chk_eq("clr_square", sq_errs(10, 20, 0), 0);
    chk_eq("clr_listo_cnt", listo_cnt, 0);
    chk_eq("clr_busy_last", busy_last, 16);

    // Second iPintar during DRAW is ignored.
    run_cmd(1'b1, 1'b0, 8'd10, 7'd20, 3'd5, 0, 0, 5);
    chk_eq("rep_nwr", n_wr, 16);
    chk_eq("rep_square", sq_errs(10, 20, 5), 0);
    chk_eq("rep_listo_cnt", listo_cnt, 1);
    chk_eq("rep_listo_cyc", listo_cyc, 17);

    // Asynchronous reset in the middle of DRAW.
    iPintar = 1'b1; iPosX = 8'd10; iPosY = 7'd20; iColor = 3'd5; iWrReady = 1'b1;
    @(posedge iClk); #1;
    iPintar = 1'b0;
    repeat (4) @(posedge iClk);
    #2;
    chk_eq("arst_pre_busy", oOcupado, 1);
    iReset = 1'b0;
    #1;
    chk_eq("arst_wren", oWrEn, 0);
    chk_eq("arst_listo", oListo, 0);
    chk_eq("arst_busy", oOcupado, 0);
    @(posedge iClk); #1;
    iReset = 1'b1;
    run_cmd(1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 0, 0, 0);
    chk_eq("arst_post_listo", listo_cnt, 0);
    chk_eq("arst_post_nwr", n_wr, 0);
    chk_eq("arst_post_busy", busy_last, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
